// File: rtl/sfm_streamer_strb_gen_2d.sv
// Strobe generator between the streamer and the TCDM sink for 2-D transfers.
// A job is n_rows rows of row_len bytes; every row starts offset bytes into
// its first beat. Leading bytes of the first beat and trailing bytes of the
// last beat of each row are masked. Beat/row counters run under an
// IDLE/RUN/DONE FSM. An optional 1-entry register slice sits on the output.
// The stream interfaces are flattened into data/valid/ready(/strb) ports.
module sfm_streamer_strb_gen_2d #(
   parameter int unsigned DW         = 288,
   parameter int unsigned SIDEBAND_W = 32,
   parameter int unsigned CNT_W      = 32,
   parameter bit          OUTPUT_REG = 1'b0,
   localparam int unsigned NB        = (DW - SIDEBAND_W) / 8,
   localparam int unsigned OW        = $clog2(NB),
   localparam int unsigned SW        = DW / 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] row_len_i,
   input  logic [CNT_W-1:0] n_rows_i,
   input  logic [OW-1:0]    offset_i,
   output logic             busy_o,
   output logic             done_o,
   input  logic [DW-1:0]    stream_i_data,
   input  logic             stream_i_valid,
   output logic             stream_i_ready,
   output logic [DW-1:0]    stream_o_data,
   output logic [SW-1:0]    stream_o_strb,
   output logic             stream_o_valid,
   input  logic             stream_o_ready
);

   localparam logic [1:0]       ST_IDLE  = 2'd0;
   localparam logic [1:0]       ST_RUN   = 2'd1;
   localparam logic [1:0]       ST_DONE  = 2'd2;
   localparam logic [CNT_W:0]   BPR_ONE  = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   NB_M1    = (CNT_W+1)'(NB - 1);
   localparam logic [CNT_W-1:0] ROW_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NB-1:0]    ALL_ONES = {NB{1'b1}};

   logic [1:0]       r_state;
   logic [OW-1:0]    r_offset;
   logic [OW-1:0]    r_end_lftovr;
   logic [CNT_W:0]   r_bpr;
   logic [CNT_W-1:0] r_n_rows;
   logic [CNT_W:0]   r_beat_cnt;
   logic [CNT_W-1:0] r_row_cnt;

   logic             w_run;
   logic             w_hs_in;
   logic             w_first;
   logic             w_last_beat;
   logic             w_last_row;
   logic             w_zero_job;
   logic [CNT_W:0]   w_len_end;
   logic [CNT_W:0]   w_bpr_next;
   logic [NB-1:0]    w_lead;
   logic [NB-1:0]    w_trail;
   logic [NB-1:0]    w_strb;

   // Row geometry is computed one bit wider than the counters so that
   // offset + row_len cannot overflow.
   assign w_len_end   = {{(CNT_W+1-OW){1'b0}}, offset_i} + {1'b0, row_len_i};
   assign w_bpr_next  = (w_len_end + NB_M1) >> OW;
   assign w_zero_job  = (row_len_i == '0) || (n_rows_i == '0);

   assign w_run       = (r_state == ST_RUN);
   assign w_hs_in     = stream_i_valid & stream_i_ready;
   assign w_first     = (r_beat_cnt == '0);
   assign w_last_beat = (r_beat_cnt == (r_bpr - BPR_ONE));
   assign w_last_row  = (r_row_cnt == (r_n_rows - ROW_ONE));

   assign busy_o      = (r_state == ST_RUN);
   assign done_o      = (r_state == ST_DONE);

   // Job FSM: latch config on start, walk beat/row counters on accepted beats.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         r_state      <= ST_IDLE;
         r_offset     <= '0;
         r_end_lftovr <= '0;
         r_bpr        <= '0;
         r_n_rows     <= '0;
         r_beat_cnt   <= '0;
         r_row_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_offset     <= offset_i;
                  r_end_lftovr <= w_len_end[OW-1:0];
                  r_bpr        <= w_bpr_next;
                  r_n_rows     <= n_rows_i;
                  r_beat_cnt   <= '0;
                  r_row_cnt    <= '0;
                  r_state      <= w_zero_job ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_hs_in) begin
                  if (w_last_beat) begin
                     r_beat_cnt <= '0;
                     if (w_last_row) begin
                        r_row_cnt <= '0;
                        r_state   <= ST_DONE;
                     end else begin
                        r_row_cnt <= r_row_cnt + ROW_ONE;
                     end
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BPR_ONE;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Byte strobe of the current beat: leading mask on the first beat of a
   // row, trailing mask on the last beat (end_lftovr of 0 means a full beat).
   always_comb begin
      w_lead  = ALL_ONES;
      w_trail = ALL_ONES;
      if (w_first) begin
         w_lead = ALL_ONES << r_offset;
      end else begin
         w_lead = ALL_ONES;
      end
      if (w_last_beat && (r_end_lftovr != '0)) begin
         w_trail = ~(ALL_ONES << r_end_lftovr);
      end else begin
         w_trail = ALL_ONES;
      end
      w_strb = w_lead & w_trail;
   end

   generate
      if (OUTPUT_REG) begin : g_slice
         logic          r_slice_valid;
         logic [DW-1:0] r_slice_data;
         logic [NB-1:0] r_slice_strb;

         assign stream_i_ready = w_run & (~r_slice_valid | stream_o_ready);
         assign stream_o_valid = r_slice_valid;
         assign stream_o_data  = r_slice_data;
         assign stream_o_strb  = r_slice_valid ? {{(SW-NB){1'b0}}, r_slice_strb} : '0;

         // One-entry slice: load on accepted beat, empty when drained.
         always_ff @(posedge clk_i) begin
            if (!rst_ni || clear_i) begin
               r_slice_valid <= 1'b0;
               r_slice_data  <= '0;
               r_slice_strb  <= '0;
            end else if (w_hs_in) begin
               r_slice_valid <= 1'b1;
               r_slice_data  <= stream_i_data;
               r_slice_strb  <= w_strb;
            end else if (stream_o_ready) begin
               r_slice_valid <= 1'b0;
            end else begin
               r_slice_valid <= r_slice_valid;
            end
         end
      end else begin : g_pass
         assign stream_i_ready = w_run & stream_o_ready;
         assign stream_o_valid = w_run & stream_i_valid;
         assign stream_o_data  = stream_i_data;
         assign stream_o_strb  = w_run ? {{(SW-NB){1'b0}}, w_strb} : '0;
      end
   endgenerate

endmodule
